hub75_bcm_scanner: RTL and testbench
====================================

Name: hub75_bcm_scanner

Overview:
- Downstream consumer of the per-channel gamma LUTs (8-bit in, 12-bit out).
- Reads gamma-corrected 12-bit RGB pixels for the top and bottom panel halves and shifts them into a HUB75 LED matrix using binary-code modulation (BCM) over 12 bitplanes.
- Generates row address, shift clock, latch and output-enable timing.
- Sits between the framebuffer-plus-gamma read path and the panel connector pins.

Parameters:
- ROW_BITS, 4: row-pair address width; the panel has 2^ROW_BITS scan rows per half.
- COL_BITS, 6: column address width; COLS = 2^COL_BITS.
- BITS, 12: bitplanes per channel; must match the gamma output width.
- BASE_CYCLES, 1: OE-on cycles for plane 0; must be ≥1. Plane p is displayed for BASE_CYCLES<<p cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- rd_en  out  1  pixel read strobe
- rd_addr  out  ROW_BITS+COL_BITS  {row, col}
- rd_data_top  in  3*BITS  {r,g,b} for the top-half pixel, valid the cycle after rd_en
- rd_data_bot  in  3*BITS  {r,g,b} for the bottom-half pixel, same timing as rd_data_top
- panel_r1/g1/b1  out  1 each  top-half data bits
- panel_r2/g2/b2  out  1 each  bottom-half data bits
- panel_clk  out  1  shift clock
- panel_lat  out  1  latch strobe
- panel_oe_n  out  1  output enable, active low
- panel_a  out  ROW_BITS  row select
- frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset values (asynchronous, no clock edge needed): rd_en=0, rd_addr=0, all panel data=0, panel_clk=0, panel_lat=0, panel_oe_n=1, panel_a=0, frame_done=0, state=IDLE, row=0, plane=0.
- All outputs are registered.
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: panel_oe_n=1. When enable=1, go to SHIFT with row=0, plane=0, col=0.
- SHIFT, lasting 2*COLS+2 cycles; column k:
  - rd_en=1 and rd_addr={row,k} in SHIFT cycle 2k.
  - Data is registered to the panel pins, visible in cycles 2k+2 and 2k+3.
  - panel_r1 = rd_data_top[2*BITS+plane], panel_g1 = rd_data_top[BITS+plane], panel_b1 = rd_data_top[plane]; same mapping for the r2/g2/b2 bits from rd_data_bot.
  - panel_clk=1 only in cycle 2k+3, giving exactly COLS rising edges per SHIFT.
  - rd_en=0 in odd cycles. panel_oe_n=1 throughout SHIFT.
- LATCH, 1 cycle: panel_lat=1, panel_oe_n=1, panel_clk=0; panel_a takes the current row value in this cycle.
- DISPLAY: panel_oe_n=0 for exactly BASE_CYCLES<<plane cycles.
  - The counter is at least BITS+clog2(BASE_CYCLES) bits wide, so there is no overflow at plane BITS-1.
  - On the last cycle: plane increments; at plane==BITS-1, plane wraps to 0 and row increments.
  - When row wraps from 2^ROW_BITS-1 to 0: frame_done=1 in the next cycle; next state is SHIFT if enable=1, else IDLE.
  - Otherwise the next state is SHIFT.
- panel_a changes only while panel_oe_n=1 (LATCH cycle).
- Frame length: 2^ROW_BITS * (BITS*(2*COLS+3) + BASE_CYCLES*(2^BITS-1)) cycles.
- Deasserting enable mid-frame: the frame completes, frame_done pulses, then the block enters IDLE. Reasserting enable restarts at row 0, plane 0.
- Asserting rst_n low mid-operation blanks the panel immediately (panel_oe_n=1). All counters clear.

Test Plan (COL_BITS=2, ROW_BITS=1, BITS=12, BASE_CYCLES=1 unless stated):
- Reset: pull rst_n low mid-DISPLAY with no clock edge -> panel_oe_n=1 and panel_a=0 immediately; after release and enable=1, the first rd_addr is 0.
- Shift data: top pixel col k r=12'h001<<k, others 0 -> at panel_clk rising edges in plane 0, r1=1,0,0,0; in plane 1, r1=0,1,0,0. rd_addr goes 0,1,2,3. Exactly 4 panel_clk pulses per SHIFT.
- OE weighting: plane p -> panel_oe_n low for exactly 2^p consecutive cycles, p=0..11. A single-cycle panel_lat precedes each DISPLAY. panel_oe_n=1 during panel_lat and SHIFT.
- Rows/frame: panel_a=0 for 12 planes, then 1, then back to 0. panel_a never changes while panel_oe_n=0. frame_done pulses one cycle every 8454 cycles.
- Enable drop: enable=0 during row 0 -> the frame completes (frame_done pulses), then IDLE with rd_en=0 and panel_oe_n=1. Re-enable restarts at rd_addr=0, plane 0.
- Full scale: top pixels all 12'hfff, bottom pixels 12'h000 -> r1=g1=b1=1 and r2=g2=b2=0 at every panel_clk edge of every plane.

Source files
------------

// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel scanner: shifts gamma-corrected RGB bitplanes into the matrix and
// weights each plane's output-enable time by binary-code modulation.
module hub75_bcm_scanner #(
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 6,
    parameter int BITS        = 12,
    parameter int BASE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic                         rd_en,
    output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
    input  logic [3*BITS-1:0]            rd_data_top,
    input  logic [3*BITS-1:0]            rd_data_bot,
    output logic                         panel_r1,
    output logic                         panel_g1,
    output logic                         panel_b1,
    output logic                         panel_r2,
    output logic                         panel_g2,
    output logic                         panel_b2,
    output logic                         panel_clk,
    output logic                         panel_lat,
    output logic                         panel_oe_n,
    output logic [ROW_BITS-1:0]          panel_a,
    output logic                         frame_done
);

    localparam int COLS = 1 << COL_BITS;
    localparam int CW   = COL_BITS + 2;
    localparam int PW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int DW   = BITS + $clog2(BASE_CYCLES) + 1;

    localparam logic [CW-1:0]       SHIFT_LAST = CW'(2 * COLS + 1);
    localparam logic [CW-1:0]       RD_LIMIT   = CW'(2 * COLS);
    localparam logic [CW-1:0]       CLK_FIRST  = CW'(3);
    localparam logic [PW-1:0]       PLANE_LAST = PW'(BITS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;
    localparam logic [DW-1:0]       BASE_W     = DW'(BASE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [DW-1:0]       disp_q, disp_d;
    logic [PW-1:0]       plane_q, plane_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic                frame_done_d;

    logic                         rd_en_q;
    logic [ROW_BITS+COL_BITS-1:0] rd_addr_q;
    logic                         r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
    logic                         pclk_q, lat_q, oe_n_q, frame_done_q;
    logic [ROW_BITS-1:0]          a_q;

    logic [BITS-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;
    logic [DW-1:0]   disp_last;
    logic            rd_en_d, pclk_d, capture;
    logic [ROW_BITS+COL_BITS-1:0] rd_addr_d;

    assign top_r = rd_data_top[3*BITS-1 -: BITS];
    assign top_g = rd_data_top[2*BITS-1 -: BITS];
    assign top_b = rd_data_top[BITS-1:0];
    assign bot_r = rd_data_bot[3*BITS-1 -: BITS];
    assign bot_g = rd_data_bot[2*BITS-1 -: BITS];
    assign bot_b = rd_data_bot[BITS-1:0];

    // Plane p stays lit for BASE_CYCLES<<p cycles; DW leaves headroom for the top plane.
    assign disp_last = (BASE_W << plane_q) - DW'(1);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        disp_d       = disp_q;
        plane_d      = plane_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SHIFT;
                    cyc_d   = '0;
                    plane_d = '0;
                    row_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cyc_q == SHIFT_LAST) begin
                    state_d = ST_LATCH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
                disp_d  = '0;
            end
            ST_DISPLAY: begin
                if (disp_q == disp_last) begin
                    state_d = ST_SHIFT;
                    cyc_d   = '0;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        row_d   = row_q + 1'b1;
                        if (row_q == ROW_LAST) begin
                            frame_done_d = 1'b1;
                            if (!enable) state_d = ST_IDLE;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end else begin
                    disp_d = disp_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from next-state values so every pin is a flop aligned to its cycle.
    assign rd_en_d   = (state_d == ST_SHIFT) && !cyc_d[0] && (cyc_d < RD_LIMIT);
    assign rd_addr_d = {row_d, cyc_d[COL_BITS:1]};
    assign pclk_d    = (state_d == ST_SHIFT) && cyc_d[0] && (cyc_d >= CLK_FIRST);
    // Read data arrives in the odd cycle after each strobe; latch it onto the pins then.
    assign capture   = (state_q == ST_SHIFT) && cyc_q[0] && (cyc_q < RD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            disp_q       <= '0;
            plane_q      <= '0;
            row_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            r1_q         <= 1'b0;
            g1_q         <= 1'b0;
            b1_q         <= 1'b0;
            r2_q         <= 1'b0;
            g2_q         <= 1'b0;
            b2_q         <= 1'b0;
            pclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            a_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            disp_q       <= disp_d;
            plane_q      <= plane_d;
            row_q        <= row_d;
            rd_en_q      <= rd_en_d;
            if (rd_en_d) rd_addr_q <= rd_addr_d;
            if (capture) begin
                r1_q <= top_r[plane_q];
                g1_q <= top_g[plane_q];
                b1_q <= top_b[plane_q];
                r2_q <= bot_r[plane_q];
                g2_q <= bot_g[plane_q];
                b2_q <= bot_b[plane_q];
            end
            pclk_q       <= pclk_d;
            lat_q        <= (state_d == ST_LATCH);
            oe_n_q       <= (state_d != ST_DISPLAY);
            if (state_d == ST_LATCH) a_q <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign panel_r1   = r1_q;
    assign panel_g1   = g1_q;
    assign panel_b1   = b1_q;
    assign panel_r2   = r2_q;
    assign panel_g2   = g2_q;
    assign panel_b2   = b2_q;
    assign panel_clk  = pclk_q;
    assign panel_lat  = lat_q;
    assign panel_oe_n = oe_n_q;
    assign panel_a    = a_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner on a 4-column, 2-row-pair, 12-plane panel.
module tb_hub75_bcm_scanner;

    localparam int RB = 1;
    localparam int CB = 2;
    localparam int NB = 12;
    localparam int BC = 1;
    localparam int FRAME_LEN = 8454;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          rd_en;
    logic [RB+CB-1:0] rd_addr;
    logic [3*NB-1:0] rd_data_top = '0;
    logic [3*NB-1:0] rd_data_bot = '0;
    logic          panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
    logic          panel_clk, panel_lat, panel_oe_n, frame_done;
    logic [RB-1:0] panel_a;

    logic [3*NB-1:0] top_pix [8];
    logic [3*NB-1:0] bot_pix [8];

    int total = 0;
    int bad = 0;

    int          cp_npulse, cp_naddr, cp_oe_len;
    logic [3:0]  cp_r1, cp_g1, cp_b1, cp_r2, cp_g2, cp_b2;
    logic [11:0] cp_addrs;
    logic [RB-1:0] cp_a_lat;
    bit          cp_blank_bad, cp_a_moved, cp_fd, cp_tmo;

    hub75_bcm_scanner #(
        .ROW_BITS(RB), .COL_BITS(CB), .BITS(NB), .BASE_CYCLES(BC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_top(rd_data_top), .rd_data_bot(rd_data_bot),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_r2(panel_r2), .panel_g2(panel_g2), .panel_b2(panel_b2),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_a(panel_a), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Framebuffer model: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_data_top <= top_pix[rd_addr];
            rd_data_bot <= bot_pix[rd_addr];
        end
    end

    task automatic set_pattern();
        for (int i = 0; i < 8; i++) begin
            top_pix[i] = {12'(1 << (i % 4)), 12'h000, 12'h000};
            bot_pix[i] = {12'h000, 12'h000, 12'(16 << (i % 4))};
        end
    endtask

    // Observes one SHIFT/LATCH/DISPLAY sequence starting from the current sample.
    task automatic capture_plane();
        int  guard;
        logic prev;
        cp_npulse = 0; cp_naddr = 0; cp_oe_len = 0;
        cp_r1 = 0; cp_g1 = 0; cp_b1 = 0; cp_r2 = 0; cp_g2 = 0; cp_b2 = 0;
        cp_addrs = 0; cp_blank_bad = 0; cp_a_moved = 0; cp_fd = 0; cp_tmo = 0;
        prev = 1'b0;
        guard = 0;
        while (panel_lat !== 1'b1 && guard < 300) begin
            if (panel_oe_n !== 1'b1) cp_blank_bad = 1;
            if (frame_done === 1'b1) cp_fd = 1;
            if (rd_en === 1'b1) begin
                if (cp_naddr < 4) cp_addrs[cp_naddr*3 +: 3] = rd_addr;
                cp_naddr++;
            end
            if (panel_clk === 1'b1 && prev === 1'b0) begin
                if (cp_npulse < 4) begin
                    cp_r1[cp_npulse] = panel_r1; cp_g1[cp_npulse] = panel_g1;
                    cp_b1[cp_npulse] = panel_b1; cp_r2[cp_npulse] = panel_r2;
                    cp_g2[cp_npulse] = panel_g2; cp_b2[cp_npulse] = panel_b2;
                end
                cp_npulse++;
            end
            prev = panel_clk;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) cp_tmo = 1;
        cp_a_lat = panel_a;
        if (panel_oe_n !== 1'b1 || panel_clk !== 1'b0) cp_blank_bad = 1;
        guard = 0;
        @(posedge clk); #1;
        while (panel_oe_n === 1'b0 && guard < 5000) begin
            if (panel_a !== cp_a_lat) cp_a_moved = 1;
            cp_oe_len++;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) cp_tmo = 1;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        int errs;
        #2 rst_n = 1'b0;
        #1;
        obs = {rd_en, rd_addr, panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2,
               panel_clk, panel_lat, panel_oe_n, panel_a, frame_done};
        total++;
        if (obs !== 15'h0004) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 15'h0004);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        errs = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rd_en !== 1'b0 || panel_oe_n !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_quiet got=%0d bad cycles want=0", errs);
        end
    endtask

    task automatic test_shift_weighting();
        int r, p;
        logic [3:0]  er1, eb2;
        logic [11:0] ea;
        set_pattern();
        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            r = i / 12;
            p = i % 12;
            er1 = (p < 4) ? 4'(1 << p) : 4'h0;
            eb2 = (p >= 4 && p < 8) ? 4'(1 << (p - 4)) : 4'h0;
            for (int k = 0; k < 4; k++) ea[k*3 +: 3] = 3'(r * 4 + k);
            capture_plane();
            total++;
            if (cp_tmo) begin bad++; $display("FAIL timeout row=%0d plane=%0d got=1 want=0", r, p); end
            total++;
            if (cp_npulse != 4) begin bad++; $display("FAIL pulses row=%0d plane=%0d got=%0d want=4", r, p, cp_npulse); end
            total++;
            if (cp_r1 !== er1) begin bad++; $display("FAIL r1_bits row=%0d plane=%0d got=%b want=%b", r, p, cp_r1, er1); end
            total++;
            if (cp_b2 !== eb2) begin bad++; $display("FAIL b2_bits row=%0d plane=%0d got=%b want=%b", r, p, cp_b2, eb2); end
            total++;
            if ({cp_g1, cp_b1, cp_r2, cp_g2} !== 16'h0) begin
                bad++; $display("FAIL zero_bits row=%0d plane=%0d got=%h want=0", r, p, {cp_g1, cp_b1, cp_r2, cp_g2});
            end
            total++;
            if (cp_naddr != 4 || cp_addrs !== ea) begin
                bad++; $display("FAIL rd_addr_seq row=%0d plane=%0d got=%h/%0d want=%h/4", r, p, cp_addrs, cp_naddr, ea);
            end
            total++;
            if (cp_oe_len != (1 << p)) begin bad++; $display("FAIL oe_len row=%0d plane=%0d got=%0d want=%0d", r, p, cp_oe_len, 1 << p); end
            total++;
            if (cp_a_lat !== RB'(r)) begin bad++; $display("FAIL panel_a row=%0d plane=%0d got=%0d want=%0d", r, p, cp_a_lat, r); end
            total++;
            if (cp_blank_bad || cp_a_moved) begin
                bad++; $display("FAIL blanking row=%0d plane=%0d got=%0b%0b want=00", r, p, cp_blank_bad, cp_a_moved);
            end
            total++;
            if (cp_fd) begin bad++; $display("FAIL early_frame_done row=%0d plane=%0d got=1 want=0", r, p); end
        end
        capture_plane();
        total++;
        if (!cp_fd) begin bad++; $display("FAIL frame_done_pulse got=0 want=1"); end
        total++;
        if (cp_a_lat !== 1'b0 || cp_addrs[2:0] !== 3'd0 || cp_oe_len != 1) begin
            bad++; $display("FAIL frame_wrap got=a%0d/addr%0d/oe%0d want=a0/addr0/oe1", cp_a_lat, cp_addrs[2:0], cp_oe_len);
        end
    endtask

    task automatic test_frame_period();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 10000) begin @(posedge clk); #1; n++; end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (frame_done !== 1'b1 && n < 10000);
        total++;
        if (n != FRAME_LEN) begin bad++; $display("FAIL frame_period got=%0d want=%0d", n, FRAME_LEN); end
    endtask

    task automatic test_enable_drop();
        int n, errs;
        enable = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (frame_done !== 1'b1 && n < 10000);
        total++;
        if (n != FRAME_LEN) begin bad++; $display("FAIL drop_frame_completes got=%0d want=%0d", n, FRAME_LEN); end
        errs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rd_en !== 1'b0 || panel_oe_n !== 1'b1 || frame_done !== 1'b0 || panel_lat !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL drop_idle got=%0d bad cycles want=0", errs); end
        enable = 1'b1;
        capture_plane();
        total++;
        if (cp_naddr != 4 || cp_addrs !== 12'b011_010_001_000) begin
            bad++; $display("FAIL restart_addr got=%h/%0d want=%h/4", cp_addrs, cp_naddr, 12'b011_010_001_000);
        end
        total++;
        if (cp_oe_len != 1 || cp_r1 !== 4'b0001) begin
            bad++; $display("FAIL restart_plane0 got=oe%0d/r1%b want=oe1/r10001", cp_oe_len, cp_r1);
        end
        capture_plane();
        total++;
        if (cp_oe_len != 2 || cp_r1 !== 4'b0010) begin
            bad++; $display("FAIL restart_plane1 got=oe%0d/r1%b want=oe2/r10010", cp_oe_len, cp_r1);
        end
    endtask

    task automatic test_full_scale();
        int p;
        for (int i = 0; i < 8; i++) begin
            top_pix[i] = 36'hfffffffff;
            bot_pix[i] = 36'h000000000;
        end
        for (int i = 0; i < 24; i++) begin
            p = (i + 2) % 12;
            capture_plane();
            total++;
            if (cp_npulse != 4 || {cp_r1, cp_g1, cp_b1} !== 12'hfff || {cp_r2, cp_g2, cp_b2} !== 12'h000) begin
                bad++; $display("FAIL full_scale plane=%0d got=%0d/%h/%h want=4/fff/000",
                                p, cp_npulse, {cp_r1, cp_g1, cp_b1}, {cp_r2, cp_g2, cp_b2});
            end
            total++;
            if (cp_oe_len != (1 << p)) begin bad++; $display("FAIL full_scale_oe plane=%0d got=%0d want=%0d", p, cp_oe_len, 1 << p); end
        end
    endtask

    task automatic test_reset_mid_display();
        int n;
        n = 0;
        while (!(panel_oe_n === 1'b0 && panel_a === 1'b1) && n < 10000) begin @(posedge clk); #1; n++; end
        total++;
        if (n >= 10000) begin bad++; $display("FAIL reach_row1_display got=timeout want=display"); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (panel_oe_n !== 1'b1 || panel_a !== 1'b0) begin
            bad++; $display("FAIL async_blank got=oe_n%0b/a%0d want=oe_n1/a0", panel_oe_n, panel_a);
        end
        total++;
        if (rd_en !== 1'b0 || rd_addr !== 3'd0 || panel_lat !== 1'b0 || panel_clk !== 1'b0) begin
            bad++; $display("FAIL async_clear got=%b/%0d/%b/%b want=0/0/0/0", rd_en, rd_addr, panel_lat, panel_clk);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        capture_plane();
        total++;
        if (cp_naddr != 4 || cp_addrs[2:0] !== 3'd0 || cp_a_lat !== 1'b0 || cp_oe_len != 1) begin
            bad++; $display("FAIL post_reset_start got=addr%0d/n%0d/a%0d/oe%0d want=addr0/n4/a0/oe1",
                            cp_addrs[2:0], cp_naddr, cp_a_lat, cp_oe_len);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            top_pix[i] = '0;
            bot_pix[i] = '0;
        end
        test_reset();
        test_shift_weighting();
        test_frame_period();
        test_enable_drop();
        test_full_scale();
        test_reset_mid_display();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
